jt49_noise_lfsr: RTL

Parametrised noise generator for the JT49 PSG family: a programmable period divider driving a configurable-length Fibonacci LFSR. It supports white and periodic noise modes, seed loading and lock-up recovery. It sits beside the tone channels and feeds the mixer's noise input; it generalises the fixed 17-bit/5-bit AY noise source.

---
 rtl/jt49_noise_lfsr.sv | 101 ++++++++++
 1 files changed

// File: rtl/jt49_noise_lfsr.sv
// JT49 noise source: period divider feeding a configurable Fibonacci LFSR.
// Optional AY-style half-rate noise clock is built when JT49_NOISE_HALF_EN is defined.
module jt49_noise_lfsr #(
  parameter int PW   = 5,
  parameter int LW   = 17,
  parameter int TAPA = 0,
  parameter int TAPB = 3
) (
  input  logic          rst_n,
  input  logic          noise_clk,
  input  logic          cen,
  input  logic [PW-1:0] period,
  input  logic          mode,
  input  logic          ld,
  input  logic [LW-1:0] seed,
  output logic          noise,
  output logic          step,
  output logic [LW-1:0] lfsr
);

  localparam logic [LW-1:0] SEED_MSB = {1'b1, {(LW-1){1'b0}}};

  logic [PW-1:0] r_cnt;
  logic [LW-1:0] r_lfsr;
  logic          r_step;

  logic [PW-1:0] w_last;
  logic          w_wrap;
  logic          w_adv;
  logic          w_zero;
  logic          w_fb;
  logic [LW-1:0] w_shift;
  logic [LW-1:0] w_seed;

  // A period of 0 divides by 1; >= lets a shortened period wrap at once.
  assign w_last = (period == '0) ? '0 : period - PW'(1);
  assign w_wrap = cen && (r_cnt >= w_last);

  // An all-zero register injects a 1 so the generator can never lock up.
  assign w_zero = (r_lfsr == '0);
  assign w_fb   = mode ? (r_lfsr[0] | w_zero)
                       : (r_lfsr[TAPA] ^ r_lfsr[TAPB] ^ w_zero);

  genvar gi;
  generate
    for (gi = 0; gi < LW - 1; gi++) begin : g_shift
      assign w_shift[gi] = r_lfsr[gi+1];
    end
  endgenerate
  assign w_shift[LW-1] = w_fb;

  assign w_seed = (seed == '0) ? SEED_MSB : seed;

`ifdef JT49_NOISE_HALF_EN
  logic r_half;

  always_ff @(posedge noise_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= 1'b0;
    end else if (ld) begin
      r_half <= 1'b0;
    end else if (w_wrap) begin
      r_half <= ~r_half;
    end
  end

  assign w_adv = w_wrap & r_half;
`else
  assign w_adv = w_wrap;
`endif

  always_ff @(posedge noise_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ld) begin
      r_cnt <= '0;
    end else if (cen) begin
      r_cnt <= w_wrap ? '0 : r_cnt + PW'(1);
    end
  end

  // Load wins over a coincident advance, which is dropped along with its step.
  always_ff @(posedge noise_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_adv & ~ld;
      if (ld) begin
        r_lfsr <= w_seed;
      end else if (w_adv) begin
        r_lfsr <= w_shift;
      end
    end
  end

  assign lfsr  = r_lfsr;
  assign noise = r_lfsr[LW-1];
  assign step  = r_step;

endmodule
